floating_point_multiplier: RTL and testbench
============================================

// Module: floating_point_multiplier
// PURPOSE
//   IEEE-754 binary32 multiplier: result = a * b, with overflow flag.
//   One registered output stage, latency 1 clk.
//   Datapath leaf, used alongside the FP adder. Inputs are sampled every cycle; no handshake.
// PARAMETERS
//   (none): format is fixed binary32 (8-bit exponent, bias 127, 23-bit fraction).
// PORTS
//   clk       input   1   single clock; all state on rising edge
//   rst       input   1   asynchronous, active-high reset
//   a         input   32  operand A, binary32
//   b         input   32  operand B, binary32
//   result    output  32  registered product, binary32
//   overflow  output  1   registered; 1 when finite operands overflow to infinity
// BEHAVIOUR
//   - Reset: while rst=1 (asynchronous), result=32'h0000_0000 and overflow=0.
//   - Latency: a/b applied before edge N appear on result/overflow after edge N.
//     New operands are accepted every cycle (throughput 1/clk).
//   - Sign: a[31]^b[31], for all cases including zero and infinity.
//   - Operand classes: exp=0 is zero; denormals are flushed to zero.
//     exp=255 with frac=0 is infinity; exp=255 with frac!=0 is NaN.
//   - Special-case priority, highest first:
//     1. Either operand NaN, or 0*inf -> 32'h7FC0_0000, overflow=0.
//     2. Either operand inf -> {sign, 8'hFF, 23'h0}, overflow=0.
//     3. Either operand zero -> {sign, 31'h0}, overflow=0.
//   - Normal path:
//     - Mantissas: 24b x 24b {1,frac} -> 48b product.
//     - Exponent: ea+eb-127, as a signed 10-bit intermediate.
//     - If product[47]=1, shift right 1 and add 1 to the exponent.
//     - Round to nearest, ties to even, using guard plus sticky (OR of the lower bits).
//     - If rounding carries to 2.0, renormalise: exponent +1, mantissa = 1.0.
//   - Final exponent >= 255 -> {sign, 8'hFF, 23'h0} and overflow=1.
//   - Final exponent <= 0 (underflow) -> {sign, 31'h0}, overflow=0. No denormal outputs.
//   - overflow is recomputed every cycle; it is not sticky.
// STRUCTURE
//   - Package fp32_pkg holds:
//     - Constants: EXP_W=8, MAN_W=23, BIAS=127, EXP_MAX=255, QNAN=32'h7FC0_0000.
//     - Class enum {ZERO, NORM, INF, NAN}.
//     - Field-unpack function.
//   - Top level: operand classify, sign/exponent add, 24x24 multiply,
//     special-case mux, output register.
//   - Sub-module fp32_normalize_round (combinational): 48b product plus 10b exponent
//     -> normalised, rounded {exp, frac} and an overflow indication.
// TESTING
//   1. a=40000000 (2.0), b=40400000 (3.0) -> result=40C00000 (6.0), overflow=0, 1 clk later.
//   2. a=3FC00000 (1.5), b=40000000 -> result=40400000 (3.0).
//      a=3F000000 (0.5), b=3E800000 (0.25) -> result=3E000000 (0.125).
//   3. a=40E66666 (7.2), b=40400000 (3.0) -> result=41ACCCCC (21.6):
//      normalise shift plus tie round-to-even.
//   4. a=7F000000, b=40000000 -> result=7F800000, overflow=1.
//      Sign variant: a=FF000000, b=40000000 -> FF800000, overflow=1.
//   5. Specials:
//      - 00000000 x 7F800000 -> 7FC00000.
//      - 80000000 x 40000000 -> 80000000.
//      - 00800000 x 00800000 -> 00000000 (underflow flush), overflow=0.
//   6. Reset and throughput: assert rst mid-stream; result=0 and overflow=0 immediately,
//      with no clock edge needed. Release rst, then apply back-to-back vectors on
//      consecutive cycles; each result appears exactly 1 clk after its inputs.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the FP datapath leaves.
package fp32_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp32_t;

  function automatic fp32_t unpack(input logic [31:0] v);
    fp32_t f;
    f.sign = v[31];
    f.exp  = v[30:23];
    f.frac = v[22:0];
    return f;
  endfunction

  // Denormals share exp=0 with zero and are therefore flushed.
  function automatic fp_class_e classify(input fp32_t f);
    if (f.exp == '0)
      return ZERO;
    else if (f.exp == EXP_W'(EXP_MAX))
      return (f.frac == '0) ? INF : NAN;
    else
      return NORM;
  endfunction

endpackage

// File: rtl/fp32_normalize_round.sv
// Combinational normalise + round-to-nearest-even for a 48b mantissa product.
module fp32_normalize_round
  import fp32_pkg::*;
(
  input  logic [47:0]       prod,
  input  logic signed [9:0] exp_in,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MAN_W-1:0]  frac_out,
  output logic              ovf,
  output logic              unf
);

  localparam logic signed [9:0] EXP_LIMIT = 10'sd255;

  logic [23:0]       mant;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [24:0]       rnd;
  logic signed [9:0] exp_n;
  logic signed [9:0] exp_f;

  // Select the leading 24 bits, guard and sticky depending on where the product's leading one sits.
  always_comb begin
    if (prod[47]) begin
      mant   = prod[47:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_n  = exp_in + 10'sd1;
    end else begin
      mant   = prod[46:23];
      guard  = prod[22];
      sticky = |prod[21:0];
      exp_n  = exp_in;
    end
    round_up = guard & (sticky | mant[0]);
    rnd      = {1'b0, mant} + 25'(round_up);
    // A carry out of rounding means the mantissa became exactly 2.0; rnd[23:1] is then zero.
    if (rnd[24]) begin
      exp_f    = exp_n + 10'sd1;
      frac_out = rnd[23:1];
    end else begin
      exp_f    = exp_n;
      frac_out = rnd[22:0];
    end
    exp_out = exp_f[7:0];
    ovf     = (exp_f >= EXP_LIMIT);
    unf     = (exp_f <= 10'sd0);
  end

endmodule

// File: rtl/floating_point_multiplier.sv
// binary32 multiplier with one registered output stage and an overflow flag.
module floating_point_multiplier
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        overflow
);

  fp32_t             fa, fb;
  fp_class_e         ca, cb;
  logic              sign;
  logic signed [9:0] exp_sum;
  logic [47:0]       prod;
  logic [EXP_W-1:0]  nr_exp;
  logic [MAN_W-1:0]  nr_frac;
  logic              nr_ovf;
  logic              nr_unf;
  logic [31:0]       result_n;
  logic              overflow_n;

  // Unpack, classify, add exponents and multiply the implicit-one mantissas.
  always_comb begin
    fa      = unpack(a);
    fb      = unpack(b);
    ca      = classify(fa);
    cb      = classify(fb);
    sign    = fa.sign ^ fb.sign;
    exp_sum = $signed({2'b00, fa.exp}) + $signed({2'b00, fb.exp}) - $signed(10'(BIAS));
    prod    = {1'b1, fa.frac} * {1'b1, fb.frac};
  end

  fp32_normalize_round u_norm (
    .prod     (prod),
    .exp_in   (exp_sum),
    .exp_out  (nr_exp),
    .frac_out (nr_frac),
    .ovf      (nr_ovf),
    .unf      (nr_unf)
  );

  // Special cases override the normal path in priority order NaN, inf, zero.
  always_comb begin
    result_n   = {sign, nr_exp, nr_frac};
    overflow_n = 1'b0;
    if (ca == NAN || cb == NAN || (ca == ZERO && cb == INF) || (ca == INF && cb == ZERO)) begin
      result_n = QNAN;
    end else if (ca == INF || cb == INF) begin
      result_n = {sign, 8'hFF, 23'h0};
    end else if (ca == ZERO || cb == ZERO) begin
      result_n = {sign, 31'h0};
    end else if (nr_ovf) begin
      result_n   = {sign, 8'hFF, 23'h0};
      overflow_n = 1'b1;
    end else if (nr_unf) begin
      result_n = {sign, 31'h0};
    end
  end

  // Output register; overflow is recomputed each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result   <= 32'h0000_0000;
      overflow <= 1'b0;
    end else begin
      result   <= result_n;
      overflow <= overflow_n;
    end
  end

endmodule

// File: tb/tb_floating_point_multiplier.sv
// Scoreboard bench for floating_point_multiplier: directed vectors, 1-clock latency.
module tb_floating_point_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] result;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  floating_point_multiplier dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] er, input logic eo, input string nm);
    exp_t e;
    @(negedge clk);
    a = va;
    b = vb;
    e.name = nm;
    e.res  = er;
    e.ovf  = eo;
    sb.push_back(e);
  endtask

  task automatic check_now(input string nm, input logic [31:0] er, input logic eo);
    checks++;
    if (result !== er || overflow !== eo) begin
      errors++;
      $display("FAIL %s: got result=%08h overflow=%b, want result=%08h overflow=%b",
               nm, result, overflow, er, eo);
    end
  endtask

  // Monitor: every vector issued before an edge is compared just after that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_now(e.name, e.res, e.ovf);
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    check_now("reset_initial", 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    apply(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, "2x3");
    apply(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, "1.5x2");
    apply(32'h3F00_0000, 32'h3E80_0000, 32'h3E00_0000, 1'b0, "0.5x0.25");
    apply(32'h40E6_6666, 32'h4040_0000, 32'h41AC_CCCC, 1'b0, "7.2x3_tie_even");
    apply(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 1'b0, "tie_round_up_odd");
    apply(32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 1'b0, "max_mant_sq");
    apply(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b1, "overflow_pos");
    apply(32'hFF00_0000, 32'h4000_0000, 32'hFF80_0000, 1'b1, "overflow_neg");
    apply(32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b0, "zero_x_inf");
    apply(32'hFF80_0000, 32'h8000_0000, 32'h7FC0_0000, 1'b0, "ninf_x_nzero");
    apply(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, "nzero_x_2");
    apply(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, "underflow");
    apply(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, "nan_x_1");
    apply(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, "ninf_x_2");
    apply(32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 1'b0, "denorm_flush");
    apply(32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 1'b0, "neg2x3");

    // Mid-stream reset: the overflow vector is registered, then rst clears it without an edge.
    apply(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b1, "pre_reset_ovf");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_now("reset_async", 32'h0, 1'b0);
    a = 32'h4000_0000;
    b = 32'h4040_0000;
    @(posedge clk);
    #1;
    check_now("reset_held", 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    apply(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, "b2b_1x1");
    apply(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, "b2b_2x3");
    apply(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b1, "b2b_ovf");
    apply(32'h3F00_0000, 32'h3E80_0000, 32'h3E00_0000, 1'b0, "b2b_ovf_clears");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
